// File: rtl/mel_log_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mel_log_buffer_if : mel energy stream in, parallel log2 frame out
// | Revision 1.0
// +----------------------------------------------------------------------------
interface mel_log_buffer_if #(
  parameter int NUM_FILTERS = 40
);
  logic [31:0] mel_data_in;
  logic        mel_valid_in;
  logic        mel_last_in;
  logic        mel_ready_out;
  logic [15:0] log_data_out [NUM_FILTERS-1:0];
  logic        log_valid_out;
  logic        log_ready_in;
  logic        frame_error_out;

  modport slave (
    input  mel_data_in, mel_valid_in, mel_last_in, log_ready_in,
    output mel_ready_out, log_data_out, log_valid_out, frame_error_out
  );

  modport master (
    output mel_data_in, mel_valid_in, mel_last_in, log_ready_in,
    input  mel_ready_out, log_data_out, log_valid_out, frame_error_out
  );
endinterface
`default_nettype wire

// File: rtl/mel_log_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mel_log_buffer : collects one frame of mel energies as Q5.11 log2 values
// | Revision 1.0
// +----------------------------------------------------------------------------
module mel_log_buffer #(
  parameter int NUM_FILTERS = 40
) (
  input  wire logic        clk_in,
  input  wire logic        rst_in,
  mel_log_buffer_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_FILTERS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      mem_q [NUM_FILTERS-1:0];
  logic [15:0]      mem_d [NUM_FILTERS-1:0];
  logic             err_q, err_d;

  logic             xfer_in;
  logic             xfer_out;
  logic [4:0]       msb;
  logic [10:0]      frac;
  logic [15:0]      log_val;

  assign xfer_in  = bus.mel_valid_in && (state_q != HOLD);
  assign xfer_out = bus.log_ready_in && (state_q == HOLD);

  // Normalise so the leading one sits at bit 31; the next 11 bits are the fraction.
  always_comb begin
    msb = '0;
    for (int i = 1; i < 32; i++) begin
      if (bus.mel_data_in[i]) msb = 5'(i);
    end
    frac    = 11'((bus.mel_data_in << (5'd31 - msb)) >> 20);
    log_val = (bus.mel_data_in == 32'd0) ? 16'h0000 : {msb, frac};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    err_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (xfer_in) begin
          for (int i = 0; i < NUM_FILTERS; i++) begin
            if (idx_q == IDX_W'(i)) mem_d[i] = log_val;
          end
          idx_d = idx_q + IDX_W'(1);
          if (bus.mel_last_in) begin
            state_d = HOLD;
            err_d   = (idx_q != LAST_IDX);
          end else if (idx_q == LAST_IDX) begin
            state_d = DRAIN;
            err_d   = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (xfer_in && bus.mel_last_in) state_d = HOLD;
      end
      HOLD: begin
        if (xfer_out) begin
          state_d = FILL;
          idx_d   = '0;
          for (int i = 0; i < NUM_FILTERS; i++) mem_d[i] = 16'h0000;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= FILL;
      idx_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_FILTERS; i++) mem_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.mel_ready_out   = (state_q != HOLD);
  assign bus.log_valid_out   = (state_q == HOLD);
  assign bus.frame_error_out = err_q;
  assign bus.log_data_out    = mem_q;
endmodule
`default_nettype wire

// File: tb/tb_mel_log_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_mel_log_buffer : directed and randomized scoreboard bench, NUM_FILTERS=4
// | Revision 1.0
// +----------------------------------------------------------------------------
module tb_mel_log_buffer;
  localparam int NF = 4;
  localparam int N_RAND = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mel_log_buffer_if #(.NUM_FILTERS(NF)) bus ();
  mel_log_buffer #(.NUM_FILTERS(NF)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic [NF*16-1:0] d;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // Reference: floor(log2(x)) in the integer field, mantissa bits below it as fraction.
  function automatic logic [15:0] log_ref(input logic [31:0] x);
    int p;
    logic [31:0] f;
    if (x == 32'd0) return 16'h0000;
    p = 0;
    while ((x >> (p + 1)) != 32'd0) p++;
    if (p >= 11) f = x >> (p - 11);
    else         f = x << (11 - p);
    return {p[4:0], f[10:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_frame(input string name, input logic [NF*16-1:0] exp);
    for (int i = 0; i < NF; i++)
      chk($sformatf("%s[%0d]", name, i), {16'h0, bus.log_data_out[i]}, {16'h0, exp[i*16 +: 16]});
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_ready"}, {31'd0, bus.mel_ready_out}, 32'd1);
    chk({name, "_valid"}, {31'd0, bus.log_valid_out}, 32'd0);
    chk({name, "_err"},   {31'd0, bus.frame_error_out}, 32'd0);
    chk_frame({name, "_data"}, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    bus.mel_data_in  = d;
    bus.mel_last_in  = l;
    bus.mel_valid_in = 1'b1;
    @(negedge clk);
    while (!bus.mel_ready_out && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("FAIL send_timeout: ready got 0 expected 1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    bus.mel_valid_in = 1'b0;
    bus.mel_last_in  = 1'b0;
  endtask

  task automatic release_frame();
    bus.log_ready_in = 1'b1;
    idle(1);
    bus.log_ready_in = 1'b0;
  endtask

  initial begin
    bus.mel_data_in  = '0;
    bus.mel_valid_in = 1'b0;
    bus.mel_last_in  = 1'b0;
    bus.log_ready_in = 1'b0;
    #3;
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reference vector frame
    send(32'h0000_0001, 1'b0);
    send(32'h0000_0003, 1'b0);
    send(32'h0000_1800, 1'b0);
    chk("vec_err_mid", {31'd0, bus.frame_error_out}, 32'd0);
    send(32'hFFFF_FFFF, 1'b1);
    chk("vec_valid", {31'd0, bus.log_valid_out}, 32'd1);
    chk("vec_err", {31'd0, bus.frame_error_out}, 32'd0);
    chk_frame("vec", {16'hFFFF, 16'h6400, 16'h0C00, 16'h0000});

    // Back-pressure in HOLD
    for (int c = 0; c < 10; c++) begin
      chk("hold_ready", {31'd0, bus.mel_ready_out}, 32'd0);
      chk("hold_valid", {31'd0, bus.log_valid_out}, 32'd1);
      chk_frame("hold", {16'hFFFF, 16'h6400, 16'h0C00, 16'h0000});
      idle(1);
    end
    release_frame();
    chk_idle_outputs("after_xfer");

    // Zero and top-bit inputs
    send(32'h0000_0000, 1'b0);
    send(32'h8000_0000, 1'b0);
    send(32'h0000_0005, 1'b0);
    send(32'h0000_0400, 1'b1);
    chk_frame("edge", {16'h5000, 16'h1200, 16'hF800, 16'h0000});
    release_frame();

    // Short frame
    send(32'h0000_0005, 1'b0);
    send(32'h0000_0007, 1'b1);
    chk("short_err", {31'd0, bus.frame_error_out}, 32'd1);
    chk("short_valid", {31'd0, bus.log_valid_out}, 32'd1);
    chk_frame("short", {16'h0000, 16'h0000, 16'h1600, 16'h1200});
    idle(1);
    chk("short_err_end", {31'd0, bus.frame_error_out}, 32'd0);
    release_frame();

    // Long frame
    send(32'h10, 1'b0);
    send(32'h20, 1'b0);
    send(32'h30, 1'b0);
    chk("long_err_early", {31'd0, bus.frame_error_out}, 32'd0);
    send(32'h40, 1'b0);
    chk("long_err", {31'd0, bus.frame_error_out}, 32'd1);
    send(32'hFFFF, 1'b0);
    chk("long_err_end", {31'd0, bus.frame_error_out}, 32'd0);
    chk("long_drain_ready", {31'd0, bus.mel_ready_out}, 32'd1);
    chk("long_drain_valid", {31'd0, bus.log_valid_out}, 32'd0);
    send(32'h1234_5678, 1'b1);
    chk("long_valid", {31'd0, bus.log_valid_out}, 32'd1);
    chk("long_err_hold", {31'd0, bus.frame_error_out}, 32'd0);
    chk_frame("long", {16'h3000, 16'h2C00, 16'h2800, 16'h2000});
    release_frame();

    // Asynchronous reset mid-frame, then in HOLD
    send(32'h9, 1'b0);
    send(32'h9, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk_idle_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    send(32'h4, 1'b0);
    send(32'h8, 1'b1);
    chk("post_rst_err", {31'd0, bus.frame_error_out}, 32'd0);
    chk_frame("post_rst", {16'h1800, 16'h1000, 16'h0800, 16'h0000});
    #3;
    rst = 1'b1;
    #1;
    chk_idle_outputs("rst_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'h100, 1'b0);
    send(32'h200, 1'b0);
    send(32'h300, 1'b0);
    send(32'h8, 1'b1);
    chk_frame("post_rst2", {16'h1800, 16'h4C00, 16'h4800, 16'h4000});
    release_frame();

    // Randomized frames against the scoreboard
    fork
      begin : drv
        logic [31:0] s [8];
        int len;
        exp_t e;
        for (int f = 0; f < N_RAND; f++) begin
          len = $urandom_range(1, 7);
          e   = '0;
          for (int k = 0; k < len; k++) begin
            case ($urandom_range(0, 3))
              0:       s[k] = 32'd0;
              1:       s[k] = $urandom;
              default: s[k] = $urandom >> $urandom_range(0, 31);
            endcase
            if (k < NF) e.d[k*16 +: 16] = log_ref(s[k]);
          end
          e.err = (len != NF);
          sb.push_back(e);
          for (int k = 0; k < len; k++) begin
            send(s[k], k == len - 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          end
        end
      end
      begin : mon
        int   got;
        int   ec;
        int   cyc;
        exp_t e;
        got = 0;
        ec  = 0;
        cyc = 0;
        while (got < N_RAND && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (bus.frame_error_out) ec++;
          if (bus.log_valid_out && bus.log_ready_in) begin
            if (sb.size() == 0) begin
              errors++;
              checks++;
              $display("FAIL rnd_unexpected_frame: got frame expected none at %0t", $time);
            end else begin
              e = sb.pop_front();
              chk_frame($sformatf("rnd%0d", got), e.d);
              chk($sformatf("rnd%0d_err_pulses", got), ec, {31'd0, e.err});
            end
            ec = 0;
            got++;
          end
        end
        if (got < N_RAND) begin
          errors++;
          checks++;
          $display("FAIL rnd_timeout: got %0d frames expected %0d", got, N_RAND);
        end
        done = 1'b1;
      end
      begin : rdy
        while (!done) begin
          @(posedge clk);
          #1;
          bus.log_ready_in = ($urandom_range(0, 3) != 0);
        end
        bus.log_ready_in = 1'b0;
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mel_log_buffer.md
MEL_LOG_BUFFER -- requirements
Module: mel_log_buffer

Interface
REQ-001 The module SHALL have parameter NUM_FILTERS, default 40, giving the number of mel filter energies per frame (legal range 2..64).
REQ-002 clk_in  input  1  The single clock; all state SHALL update on its rising edge.
REQ-003 rst_in  input  1  Reset, asynchronous and active-high.
REQ-004 mel_data_in  input  32  Unsigned mel filter energy, one per transfer, filter 0 first.
REQ-005 mel_valid_in  input  1  Upstream asserts when mel_data_in is valid.
REQ-006 mel_last_in  input  1  Marks the final energy of a frame.
REQ-007 mel_ready_out  output  1  High when the block accepts a sample; a transfer SHALL occur on a cycle with mel_valid_in and mel_ready_out both high.
REQ-008 log_data_out  output  16 x NUM_FILTERS  Unpacked array [NUM_FILTERS-1:0] of log2 values, index = filter number; feeds the DCT stage's parallel input.
REQ-009 log_valid_out  output  1  High while a complete frame is held in log_data_out.
REQ-010 log_ready_in  input  1  Downstream accept; a frame transfer SHALL occur on a cycle with log_valid_out and log_ready_in both high.
REQ-011 frame_error_out  output  1  Single-cycle pulse on a frame-length mismatch.

Function
REQ-012 States: FILL, DRAIN, HOLD; mel_ready_out SHALL be high in FILL and DRAIN, low in HOLD.
REQ-013 Log format SHALL be unsigned Q5.11: bits [15:11] = index of the most significant set bit of mel_data_in (0..31); bits [10:0] = the 11 bits immediately below that bit, zero-padded on the right when fewer than 11 exist.
REQ-014 An input of 0 SHALL produce 0x0000.
REQ-015 Log conversion SHALL be combinational on the accepted sample, with the result written to buffer entry idx on the accepting edge; idx is a write counter of width $clog2(NUM_FILTERS+1), zero in FILL's initial cycle.
REQ-016 FILL: each transfer writes entry idx and increments idx.
REQ-017 FILL, transfer with mel_last_in=1 and idx==NUM_FILTERS-1: go to HOLD.
REQ-018 FILL, transfer with mel_last_in=1 and idx<NUM_FILTERS-1 (short frame): go to HOLD; unwritten entries remain 0; pulse frame_error_out.
REQ-019 FILL, transfer with mel_last_in=0 and idx==NUM_FILTERS-1 (frame full, no last): go to DRAIN; pulse frame_error_out.
REQ-020 DRAIN: accept and discard samples; on a transfer with mel_last_in=1, go to HOLD; buffer SHALL NOT change.
REQ-021 log_valid_out SHALL equal (state==HOLD), asserting the cycle after the last-sample transfer (latency 1 cycle).
REQ-022 HOLD: log_data_out and log_valid_out SHALL be stable until the transfer; on transfer, go to FILL, clear every buffer entry to 0 and idx to 0 on that same edge.
REQ-023 No sample SHALL be accepted on the HOLD-to-FILL transfer cycle; the earliest next sample is accepted one cycle later.
REQ-024 frame_error_out SHALL be low in all cycles other than those given in REQ-018/019.

Reset
REQ-025 While rst_in is high, regardless of clock: state=FILL, idx=0, all buffer entries 0, log_valid_out=0, frame_error_out=0, mel_ready_out=1 combinationally from state.
REQ-026 Reset asserted mid-frame or in HOLD SHALL discard the partial or held frame with no output transfer; the first frame after reset begins with filter 0.

Verification
REQ-027 NUM_FILTERS=4, inputs 0x00000001, 0x00000003, 0x00001800, 0xFFFFFFFF (last on 4th) -> log_data_out = {0x0000, 0x0C00, 0x6400, 0xFFFF}, log_valid_out high 1 cycle after the 4th transfer, frame_error_out never high.
REQ-028 Inputs 0x00000000 and 0x80000000 -> entries 0x0000 and 0xF800.
REQ-029 log_ready_in held low 10 cycles in HOLD -> mel_ready_out low and log_data_out stable for all 10 cycles; log_ready_in high -> one transfer, then FILL with buffer cleared.
REQ-030 Short frame (2 samples, last on 2nd, NUM_FILTERS=4) -> frame_error_out 1-cycle pulse, HOLD with entries 2,3 = 0x0000.
REQ-031 Long frame (6 samples, last on 6th) -> pulse on 4th transfer, samples 5-6 discarded, HOLD after 6th with the first 4 values.
REQ-032 rst_in pulsed asynchronously mid-frame and in HOLD -> outputs reach reset values immediately; the following frame is captured correctly from index 0.
